uart_tx_ahb_sequencer: RTL
==========================

// Module: uart_tx_ahb_sequencer
// PURPOSE
//  AHB-Lite single-master sequencer between the RISC-V core's 32-bit output
//  register and the AHB_APB_UART slave. It accepts a word over a valid/ready
//  handshake and splits it into 1-4 bytes, LSB first. Before each byte it polls
//  the UART status register until the TX FIFO is not full, then writes the
//  byte to the TX data register. It reports done and sticky error, and it
//  replaces the free-running D_FF capture of CPU output.
// PARAMETERS
//  UART_BASE    32'h0000_0000  base address of the UART APB window
//  TXDATA_OFS   32'h0000_0000  offset of the TX data register
//  STATUS_OFS   32'h0000_0004  offset of the status register
//  TXFULL_BIT   1              bit of the status word meaning "TX FIFO full"
//  POLL_LIMIT   1023           maximum consecutive full polls before a timeout error
// PORTS
//  clk_i         in   1   system clock, also used as HCLK
//  rst_ni        in   1   asynchronous, active-low reset
//  word_valid_i  in   1   word_i and nbytes_i are valid
//  word_i        in   32  word to transmit, byte 0 = word_i[7:0]
//  nbytes_i      in   2   number of bytes minus 1 (0 -> 1 byte, 3 -> 4 bytes)
//  word_ready_o  out  1   sequencer can accept a word
//  clr_err_i     in   1   clears err_o and leaves the ERR state
//  busy_o        out  1   a word is in progress
//  done_o        out  1   1-cycle pulse: last byte written with OKAY
//  err_o         out  1   sticky: bus error or poll timeout
//  HSEL          out  1   UART slave select
//  HADDR         out  32  transfer address
//  HTRANS        out  2   2'b00 IDLE, 2'b10 NONSEQ
//  HWRITE        out  1   1 = write, 0 = read
//  HSIZE         out  3   always 3'b000 (byte)
//  HWDATA        out  32  {24'b0, current byte}
//  HREADY        in   1   slave HREADYout
//  HRESP         in   2   2'b00 = OKAY, anything else = error
//  HRDATA        in   32  status read data
// BEHAVIOUR
//  Reset (asynchronous, any state):
//   - state IDLE; word_ready_o=1; busy/done/err=0; HSEL=0; HTRANS=IDLE
//   - HADDR=0; HWRITE=0; HWDATA=0; byte index=0; poll count=0
//   - HSIZE=3'b000 at all times
//  Accept: word_valid_i & word_ready_o in IDLE.
//   - Latch word_i and nbytes_i; clear byte index and poll count.
//   - Next cycle is POLL_A; word_ready_o=0 and busy_o=1 outside IDLE.
//  States:
//   - POLL_A: 1-cycle address phase; HSEL=1, HTRANS=NONSEQ, HWRITE=0,
//     HADDR=UART_BASE+STATUS_OFS. Always goes to POLL_D.
//   - POLL_D: HTRANS=IDLE; wait while HREADY=0. On HREADY=1:
//     - HRESP!=OKAY -> ERR
//     - HRDATA[TXFULL_BIT]=1 -> poll count+1; if count reaches POLL_LIMIT -> ERR,
//       else -> POLL_A
//     - otherwise -> WR_A with poll count=0
//   - WR_A: HTRANS=NONSEQ, HWRITE=1, HADDR=UART_BASE+TXDATA_OFS. -> WR_D.
//   - WR_D: HTRANS=IDLE; HWDATA={24'b0, word[8*idx+:8]} held until HREADY=1.
//     On HREADY=1:
//     - HRESP!=OKAY -> ERR
//     - idx==nbytes -> IDLE with done_o=1 for that one cycle
//     - otherwise idx+1 -> POLL_A
//   - ERR: err_o=1, busy_o=0, word_ready_o=0, bus IDLE; remaining bytes dropped.
//     clr_err_i=1 -> IDLE next cycle with err_o=0.
//  Timing: with zero wait states, each byte takes 4 cycles (POLL_A, POLL_D,
//   WR_A, WR_D). A 4-byte word completes in 16 cycles after the accept.
//  Simultaneous events:
//   - clr_err_i outside ERR is ignored.
//   - word_valid_i during busy is not accepted; the source must hold it.
//   - A new word may be accepted in the cycle after done_o.
//  HSEL is 1 only in POLL_A, POLL_D, WR_A and WR_D.
//  There is no pipelining of address and data phases; the next NONSEQ is never
//  issued in the same cycle as a data-phase completion.
// TESTING
//  - Reset mid-WR_D with HREADY held 0: HTRANS=00, HSEL=0, ready=1 at once;
//    no done_o afterwards.
//  - word 32'hA1B2C3D4, nbytes 3, HREADY=1, status 0: TX writes B0=D4, B1=C3,
//    B2=B2, B3=A1; done_o at cycle 16.
//  - nbytes 0, word 32'h0000_0055: one status read, one write of 8'h55;
//    done_o at cycle 4.
//  - Status TXFULL=1 for 3 polls then 0: 3 extra POLL_A/POLL_D pairs, then the
//    write; err_o stays 0.
//  - TXFULL stuck at 1: err_o=1 after POLL_LIMIT polls; clr_err_i -> IDLE,
//    word_ready_o=1.
//  - HRESP=2'b01 on the 2nd byte's write: ERR, only byte 0 was written;
//    a new word after clear sends fully.

Source files
------------

// File: rtl/uart_tx_ahb_sequencer_if.sv
// Handshake and AHB-Lite bundle between the CPU word source, the TX sequencer
// and the UART slave. The master modport is the sequencer's view.
interface uart_tx_ahb_sequencer_if;
  // word source handshake and status
  logic        word_valid_i;
  logic [31:0] word_i;
  logic [1:0]  nbytes_i;
  logic        word_ready_o;
  logic        clr_err_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  // AHB-Lite
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    input  word_valid_i, word_i, nbytes_i, clr_err_i,
    input  HREADY, HRESP, HRDATA,
    output word_ready_o, busy_o, done_o, err_o,
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );

  modport slave (
    output word_valid_i, word_i, nbytes_i, clr_err_i,
    output HREADY, HRESP, HRDATA,
    input  word_ready_o, busy_o, done_o, err_o,
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );
endinterface

// File: rtl/uart_tx_ahb_sequencer.sv
// AHB-Lite single-master sequencer: takes a 1-4 byte word, and for each byte
// (LSB first) polls the UART status until the TX FIFO is not full, then writes
// the byte to the TX data register. Address and data phases never overlap.
module uart_tx_ahb_sequencer #(
  parameter logic [31:0] UART_BASE  = 32'h0000_0000,
  parameter logic [31:0] TXDATA_OFS = 32'h0000_0000,
  parameter logic [31:0] STATUS_OFS = 32'h0000_0004,
  parameter int unsigned TXFULL_BIT = 1,
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  uart_tx_ahb_sequencer_if.master  bus
);

  localparam logic [31:0] TXDATA_ADDR = UART_BASE + TXDATA_OFS;
  localparam logic [31:0] STATUS_ADDR = UART_BASE + STATUS_OFS;
  localparam int unsigned CNT_W       = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_A,
    S_POLL_D,
    S_WR_A,
    S_WR_D,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        word_q, word_d;
  logic [1:0]         nbytes_q, nbytes_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   poll_cnt_q, poll_cnt_d;

  logic               resp_ok;
  logic               last_byte;

  assign resp_ok   = (bus.HRESP == 2'b00);
  assign last_byte = (idx_q == nbytes_q);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      nbytes_q   <= '0;
      idx_q      <= '0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      nbytes_q   <= nbytes_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  // Next-state and datapath update: poll, write, advance byte, or error out
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    nbytes_d   = nbytes_q;
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.word_valid_i) begin
          state_d    = S_POLL_A;
          word_d     = bus.word_i;
          nbytes_d   = bus.nbytes_i;
          idx_d      = '0;
          poll_cnt_d = '0;
        end
      end
      S_POLL_A: state_d = S_POLL_D;
      S_POLL_D: begin
        if (bus.HREADY) begin
          if (!resp_ok) begin
            state_d = S_ERR;
          end else if (bus.HRDATA[TXFULL_BIT]) begin
            poll_cnt_d = poll_cnt_q + CNT_W'(1);
            state_d    = (poll_cnt_d == CNT_W'(POLL_LIMIT)) ? S_ERR : S_POLL_A;
          end else begin
            poll_cnt_d = '0;
            state_d    = S_WR_A;
          end
        end
      end
      S_WR_A: state_d = S_WR_D;
      S_WR_D: begin
        if (bus.HREADY) begin
          if (!resp_ok) begin
            state_d = S_ERR;
          end else if (last_byte) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_POLL_A;
          end
        end
      end
      S_ERR: begin
        if (bus.clr_err_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; done_o flags the OKAY completion of the last write
  always_comb begin
    bus.word_ready_o = (state_q == S_IDLE);
    bus.busy_o       = (state_q == S_POLL_A) || (state_q == S_POLL_D) ||
                       (state_q == S_WR_A)   || (state_q == S_WR_D);
    bus.err_o        = (state_q == S_ERR);
    bus.done_o       = (state_q == S_WR_D) && bus.HREADY && resp_ok && last_byte;
    bus.HSEL         = bus.busy_o;
    bus.HTRANS       = ((state_q == S_POLL_A) || (state_q == S_WR_A)) ? 2'b10 : 2'b00;
    bus.HWRITE       = (state_q == S_WR_A) || (state_q == S_WR_D);
    bus.HSIZE        = 3'b000;
    bus.HADDR        = '0;
    bus.HWDATA       = '0;
    if ((state_q == S_POLL_A) || (state_q == S_POLL_D)) bus.HADDR = STATUS_ADDR;
    if (bus.HWRITE) bus.HADDR = TXDATA_ADDR;
    if (state_q == S_WR_D) bus.HWDATA = {24'h0, word_q[{idx_q, 3'b000} +: 8]};
  end

endmodule
